// File: rtl/writeback_unit_if.sv
// Bus bundle for the writeback unit: ALU results, load returns, load issue,
// and the register-file write port with scoreboard status.
interface writeback_unit_if #(
  parameter int DATA_W = 32
) ();
  logic              alu_valid;
  logic [4:0]        alu_rd;
  logic [DATA_W-1:0] alu_data;

  logic              ld_valid;
  logic              ld_ready;
  logic [4:0]        ld_rd;
  logic [DATA_W-1:0] ld_data;

  logic              iss_valid;
  logic [4:0]        iss_rd;

  logic [31:0]       busy;
  logic              wb_en;
  logic [4:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              ld_drop;

  // The writeback unit is the slave; the core pipeline around it is the master.
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data,
    input  iss_valid, iss_rd,
    output ld_ready, busy, wb_en, wb_rd, wb_data, ld_drop
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data,
    output iss_valid, iss_rd,
    input  ld_ready, busy, wb_en, wb_rd, wb_data, ld_drop
  );
endinterface

// File: rtl/writeback_unit.sv
// Register-file writeback arbiter: ALU results take priority, load returns wait
// in a small FIFO, and a busy scoreboard tracks registers with loads in flight.
module writeback_unit #(
  parameter int LQ_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  writeback_unit_if.slave  bus
);

  localparam int DATA_W = 32;
  localparam int RD_W   = 5;
  localparam int AW     = (LQ_DEPTH > 2) ? $clog2(LQ_DEPTH) : 1;
  localparam int CW     = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(LQ_DEPTH);

  // One-hot register mask; x0 never appears in the scoreboard.
  function automatic logic [31:0] rd_mask(input logic [RD_W-1:0] rd);
    logic [31:0] m;
    m = 32'd1 << rd;
    m[0] = 1'b0;
    return m;
  endfunction

  logic [RD_W-1:0]   lq_rd_q   [LQ_DEPTH];
  logic [DATA_W-1:0] lq_data_q [LQ_DEPTH];

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q,  count_d;

  logic              wb_en_q,   wb_en_d;
  logic [RD_W-1:0]   wb_rd_q,   wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [31:0]       busy_q,    busy_d;
  logic              ld_drop_q, ld_drop_d;

  logic              ld_ready;
  logic              push;
  logic              alu_sel;
  logic              lq_sel;
  logic [RD_W-1:0]   head_rd;
  logic [DATA_W-1:0] head_data;

  // Readiness comes only from registered count: a full queue refuses even
  // while it pops, so there is no combinational path from pop to ld_ready.
  assign ld_ready  = (count_q < DEPTH_C);
  assign push      = bus.ld_valid && ld_ready;
  assign head_rd   = lq_rd_q[rd_ptr_q];
  assign head_data = lq_data_q[rd_ptr_q];
  assign alu_sel   = bus.alu_valid && (bus.alu_rd != '0);
  assign lq_sel    = !alu_sel && (count_q != '0);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    wb_en_d   = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    busy_d    = busy_q;
    ld_drop_d = ld_drop_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (lq_sel) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(push) - CW'(lq_sel);

    if (bus.ld_valid && !ld_ready) begin
      ld_drop_d = 1'b1;
    end

    // ALU wins the write port; a queue pop of rd 0 still burns the slot.
    if (alu_sel) begin
      wb_en_d   = 1'b1;
      wb_rd_d   = bus.alu_rd;
      wb_data_d = bus.alu_data;
    end else if (lq_sel && (head_rd != '0)) begin
      wb_en_d   = 1'b1;
      wb_rd_d   = head_rd;
      wb_data_d = head_data;
    end

    // Clear before set so a same-cycle issue to the committing register wins.
    if (lq_sel) begin
      busy_d = busy_d & ~rd_mask(head_rd);
    end
    if (bus.iss_valid) begin
      busy_d = busy_d | rd_mask(bus.iss_rd);
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      wb_en_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      busy_q    <= '0;
      ld_drop_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      wb_en_q   <= wb_en_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      busy_q    <= busy_d;
      ld_drop_q <= ld_drop_d;
    end
  end

  // Queue storage is pure data; stale slots are never read because count gates them.
  always_ff @(posedge clk) begin
    if (push) begin
      lq_rd_q[wr_ptr_q]   <= bus.ld_rd;
      lq_data_q[wr_ptr_q] <= bus.ld_data;
    end
  end

  assign bus.ld_ready = ld_ready;
  assign bus.busy     = busy_q;
  assign bus.wb_en    = wb_en_q;
  assign bus.wb_rd    = wb_rd_q;
  assign bus.wb_data  = wb_data_q;
  assign bus.ld_drop  = ld_drop_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: stimulus pushes expected writes into a
// scoreboard queue that a negedge monitor drains whenever wb_en is seen.
module tb_writeback_unit;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  exp_t exp_q[$];

  writeback_unit_if bus ();

  writeback_unit #(.LQ_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.alu_valid = 1'b0;
    bus.alu_rd    = '0;
    bus.alu_data  = '0;
    bus.ld_valid  = 1'b0;
    bus.ld_rd     = '0;
    bus.ld_data   = '0;
    bus.iss_valid = 1'b0;
    bus.iss_rd    = '0;
  endtask

  task automatic expect_wb(input logic [4:0] rd, input logic [31:0] data);
    exp_t e;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Monitor: every write the DUT presents must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.wb_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_wb: got rd %0d data 0x%08h, required no write",
                   bus.wb_rd, bus.wb_data);
        end else begin
          e = exp_q.pop_front();
          chk("sb_wb_rd", {27'd0, bus.wb_rd}, {27'd0, e.rd});
          chk("sb_wb_data", bus.wb_data, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    idle();
    rst = 1'b1;
    repeat (2) step();

    // Reset state
    chk("rst_wb_en",    {31'd0, bus.wb_en},    32'd0);
    chk("rst_busy",     bus.busy,              32'd0);
    chk("rst_ld_ready", {31'd0, bus.ld_ready}, 32'd1);
    chk("rst_ld_drop",  {31'd0, bus.ld_drop},  32'd0);
    rst = 1'b0;
    step();

    // ALU write appears one cycle later
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd5;
    bus.alu_data  = 32'hDEADBEEF;
    expect_wb(5'd5, 32'hDEADBEEF);
    step();
    chk("alu_wb_en",   {31'd0, bus.wb_en}, 32'd1);
    chk("alu_wb_rd",   {27'd0, bus.wb_rd}, 32'd5);
    chk("alu_wb_data", bus.wb_data,        32'hDEADBEEF);
    idle();
    step();
    chk("idle_wb_en",      {31'd0, bus.wb_en}, 32'd0);
    chk("idle_wb_data_hold", bus.wb_data,      32'hDEADBEEF);

    // Issue rd 7, load returns three cycles later
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd7;
    step();
    chk("busy7_set", {31'd0, bus.busy[7]}, 32'd1);
    idle();
    step();
    chk("busy7_hold", {31'd0, bus.busy[7]}, 32'd1);
    step();
    bus.ld_valid = 1'b1;
    bus.ld_rd    = 5'd7;
    bus.ld_data  = 32'h11;
    expect_wb(5'd7, 32'h11);
    step();
    idle();
    chk("ld_no_fallthrough", {31'd0, bus.wb_en}, 32'd0);
    chk("busy7_pending",     {31'd0, bus.busy[7]}, 32'd1);
    step();
    chk("ld7_wb_en",   {31'd0, bus.wb_en}, 32'd1);
    chk("ld7_wb_rd",   {27'd0, bus.wb_rd}, 32'd7);
    chk("busy7_clear", {31'd0, bus.busy[7]}, 32'd0);

    // ALU floods for 6 cycles while loads fill the queue and one overflows
    for (int i = 0; i < 6; i++) begin
      bus.alu_valid = 1'b1;
      bus.alu_rd    = 5'd3;
      bus.alu_data  = 32'h300 + 32'(i);
      expect_wb(5'd3, 32'h300 + 32'(i));
      if (i < 4) begin
        chk("fill_ld_ready", {31'd0, bus.ld_ready}, 32'd1);
        bus.ld_valid = 1'b1;
        bus.ld_rd    = 5'(10 + i);
        bus.ld_data  = 32'hA0 + 32'(i);
      end else if (i == 4) begin
        chk("full_ld_ready", {31'd0, bus.ld_ready}, 32'd0);
        chk("pre_drop",      {31'd0, bus.ld_drop},  32'd0);
        bus.ld_valid = 1'b1;
        bus.ld_rd    = 5'd14;
        bus.ld_data  = 32'hEE;
      end else begin
        bus.ld_valid = 1'b0;
        chk("ld_drop_set", {31'd0, bus.ld_drop}, 32'd1);
      end
      step();
    end
    for (int i = 0; i < 4; i++) expect_wb(5'(10 + i), 32'hA0 + 32'(i));
    idle();
    chk("full_pop_ld_ready", {31'd0, bus.ld_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("drain_wb_en", {31'd0, bus.wb_en}, 32'd1);
      chk("drain_wb_rd", {27'd0, bus.wb_rd}, 32'(10 + i));
    end
    chk("drained_ld_ready", {31'd0, bus.ld_ready}, 32'd1);
    step();
    chk("drained_wb_en", {31'd0, bus.wb_en}, 32'd0);

    // ALU rd 0 is discarded and yields the slot to a queued load
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd0;
    bus.alu_data  = 32'hBAD;
    bus.ld_valid  = 1'b1;
    bus.ld_rd     = 5'd20;
    bus.ld_data   = 32'h2020;
    expect_wb(5'd20, 32'h2020);
    step();
    chk("alu_rd0_no_wb", {31'd0, bus.wb_en}, 32'd0);
    bus.ld_valid = 1'b0;
    bus.alu_data = 32'hBAD2;
    step();
    chk("rd0_slot_wb_en", {31'd0, bus.wb_en}, 32'd1);
    chk("rd0_slot_wb_rd", {27'd0, bus.wb_rd}, 32'd20);
    idle();

    // Load to rd 0 pops silently and consumes a selection cycle
    bus.ld_valid = 1'b1;
    bus.ld_rd    = 5'd0;
    bus.ld_data  = 32'h55;
    step();
    bus.ld_rd    = 5'd21;
    bus.ld_data  = 32'h21;
    expect_wb(5'd21, 32'h21);
    step();
    idle();
    chk("ld_rd0_no_wb",  {31'd0, bus.wb_en}, 32'd0);
    chk("ld_rd0_rd_hold", {27'd0, bus.wb_rd}, 32'd20);
    step();
    chk("ld21_wb_en", {31'd0, bus.wb_en}, 32'd1);
    chk("ld21_wb_rd", {27'd0, bus.wb_rd}, 32'd21);
    step();

    // Issue to rd 9 in the same cycle its load commits: set wins
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd9;
    step();
    idle();
    chk("busy9_set", {31'd0, bus.busy[9]}, 32'd1);
    bus.ld_valid = 1'b1;
    bus.ld_rd    = 5'd9;
    bus.ld_data  = 32'h99;
    expect_wb(5'd9, 32'h99);
    step();
    idle();
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd9;
    step();
    idle();
    chk("ld9_wb_rd",      {27'd0, bus.wb_rd},   32'd9);
    chk("busy9_set_wins", {31'd0, bus.busy[9]}, 32'd1);
    step();

    // Reset mid-operation with three queued loads
    for (int i = 0; i < 3; i++) begin
      bus.alu_valid = 1'b1;
      bus.alu_rd    = 5'd3;
      bus.alu_data  = 32'h700 + 32'(i);
      expect_wb(5'd3, 32'h700 + 32'(i));
      bus.ld_valid  = 1'b1;
      bus.ld_rd     = (i == 0) ? 5'd1 : (i == 1) ? 5'd2 : 5'd4;
      bus.ld_data   = 32'(i + 1);
      bus.iss_valid = (i == 0);
      bus.iss_rd    = 5'd8;
      step();
    end
    idle();
    chk("pre_rst_busy",     bus.busy,              32'h0000_0300);
    chk("pre_rst_ld_ready", {31'd0, bus.ld_ready}, 32'd1);
    chk("pre_rst_ld_drop",  {31'd0, bus.ld_drop},  32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_busy",     bus.busy,              32'd0);
    chk("async_rst_ld_ready", {31'd0, bus.ld_ready}, 32'd1);
    chk("async_rst_ld_drop",  {31'd0, bus.ld_drop},  32'd0);
    chk("async_rst_wb_en",    {31'd0, bus.wb_en},    32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("post_rst_no_wb", {31'd0, bus.wb_en}, 32'd0);
    end
    chk("post_rst_ld_ready", {31'd0, bus.ld_ready}, 32'd1);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL provide parameter LQ_DEPTH, default 4, meaning load-return queue depth in entries (power of two, at least 2).
REQ-002 SHALL provide port clk, input, 1, sole clock; all state updates on posedge.
REQ-003 SHALL provide port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL provide port alu_valid, input, 1, ALU result present this cycle; always accepted, no ready.
REQ-005 SHALL provide port alu_rd, input, 5, ALU destination register.
REQ-006 SHALL provide port alu_data, input, 32, ALU result.
REQ-007 SHALL provide port ld_valid, input, 1, load-return data present.
REQ-008 SHALL provide port ld_ready, output, 1, load queue can accept an entry this cycle.
REQ-009 SHALL provide port ld_rd, input, 5, load destination register.
REQ-010 SHALL provide port ld_data, input, 32, load data.
REQ-011 SHALL provide port iss_valid, input, 1, load issued; marks its destination pending.
REQ-012 SHALL provide port iss_rd, input, 5, destination of the issued load.
REQ-013 SHALL provide port busy, output, 32, per-register pending-load scoreboard; bit 0 always 0.
REQ-014 SHALL provide port wb_en, output, 1, register-file write enable.
REQ-015 SHALL provide port wb_rd, output, 5, register-file write index.
REQ-016 SHALL provide port wb_data, output, 32, register-file write data.
REQ-017 SHALL provide port ld_drop, output, 1, sticky error: ld_valid seen while ld_ready low.

Function
REQ-018 SHALL register wb_en, wb_rd and wb_data; an accepted write appears exactly one cycle after its selection cycle.
REQ-019 SHALL select the ALU request whenever alu_valid is high and alu_rd is nonzero; ALU has strict priority over the load queue.
REQ-020 SHALL select the load queue head in any cycle with no ALU selection and a non-empty queue, then pop that head.
REQ-021 SHALL discard alu_valid requests with alu_rd 0 (no wb_en), leaving the cycle free for the queue.
REQ-022 SHALL pop load entries with rd 0 without asserting wb_en; the pop consumes a selection cycle.
REQ-023 SHALL drive wb_en low, holding wb_rd and wb_data at their previous values, in cycles with no selection.
REQ-024 SHALL enqueue ld_rd/ld_data when ld_valid and ld_ready are both high; FIFO order, pointers wrap modulo LQ_DEPTH.
REQ-025 SHALL provide no fall-through: an entry enqueued in cycle N is selectable no earlier than cycle N+1 (wb_en at N+2).
REQ-026 SHALL compute ld_ready as count < LQ_DEPTH from registered state only; when full, ld_ready stays low even during a pop.
REQ-027 SHALL set sticky ld_drop and discard the data when ld_valid is high while ld_ready is low; only reset clears it.
REQ-028 SHALL set busy[iss_rd] on iss_valid with nonzero iss_rd, visible the next cycle.
REQ-029 SHALL clear busy[rd] in the cycle a load entry with nonzero rd is selected, visible the next cycle.
REQ-030 SHALL let set win over clear when issue and load-commit target the same register in one cycle.
REQ-031 SHALL leave busy unchanged on ALU writes, including ALU writes to a busy register.

Reset
REQ-032 SHALL, on rst high, immediately clear wb_en, wb_rd, wb_data, busy, ld_drop and the queue count and pointers, and drive ld_ready high.
REQ-033 SHALL discard queued entries on reset mid-operation; no wb_en in the first cycle after rst deasserts.

Verification
REQ-034 SHALL be verified with: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF at cycle N -> wb_en=1, wb_rd=5, wb_data=0xDEADBEEF at N+1.
REQ-035 SHALL be verified with: iss_rd=7 at N; ld rd=7, data=0x11 at N+3 with no ALU traffic -> busy[7]=1 from N+1; wb_en with rd=7 at N+5; busy[7]=0 from N+5.
REQ-036 SHALL be verified with: alu_valid held high (rd=3) for 6 cycles while 4 loads arrive -> ld_ready low after the 4th; 5th ld_valid sets ld_drop; after ALU stops, the 4 loads write in arrival order on consecutive cycles.
REQ-037 SHALL be verified with: alu_rd=0 together with a queued load -> load written in that slot; no wb_en for rd 0.
REQ-038 SHALL be verified with: iss_rd=9 in the same cycle a load to rd 9 is selected -> busy[9]=1 next cycle.
REQ-039 SHALL be verified with: rst pulsed with 3 queued entries and busy=0x0000_0300 -> busy=0, ld_ready=1, ld_drop=0, and no wb_en after release.
